// File: rtl/milano_pkg.sv
// Shared core package: divider operation encoding and FSM state type.
// Imported by EX-stage units and their benches.
package milano_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    function automatic logic div_op_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_op_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Ports: clk_i, rst_ni, div_start_i, div_op_i, dividend_i, divisor_i,
//        flush_i -> stallreq_o, result_o, result_valid_o.
module div_unit
    import milano_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             div_start_i,
    input  div_op_e          div_op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             stallreq_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o
);

    localparam logic [5:0]       LAST    = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [5:0]       cnt_q;
    logic             rem_op_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;

    logic             accept;
    logic             in_signed;
    logic             in_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             geq;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] final_res;

    // Operand decode for the start cycle
    always_comb begin
        in_signed = div_op_signed(div_op_i);
        in_rem    = div_op_rem(div_op_i);
        a_neg     = in_signed & dividend_i[WIDTH-1];
        b_neg     = in_signed & divisor_i[WIDTH-1];
        a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_zero  = (divisor_i == '0);
        ovf       = in_signed & (dividend_i == INT_MIN)
                    & (divisor_i == '1);
        special   = div_zero | ovf;
        special_res = '0;
        unique case (1'b1)
            div_zero: special_res = in_rem ? dividend_i : '1;
            ovf:      special_res = in_rem ? '0 : INT_MIN;
            default:  special_res = '0;
        endcase
    end

    // One restoring step. rem_q < dvs_q always holds, so the shifted
    // partial remainder is below 2*dvs_q and the WIDTH+1 bit
    // difference's top bit is a clean borrow flag.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        geq       = ~diff[WIDTH];
        rem_next  = geq ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], geq};
        if (rem_op_q) begin
            final_res = rem_neg_q ? (~rem_next + 1'b1) : rem_next;
        end else begin
            final_res = quo_neg_q ? (~quo_next + 1'b1) : quo_next;
        end
    end

    assign accept = (state_q == DIV_IDLE) & div_start_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        stallreq_o     = 1'b0;
        result_valid_o = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                stallreq_o = div_start_i;
                if (div_start_i) begin
                    state_d = special ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stallreq_o = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                result_valid_o = 1'b1;
                state_d        = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (flush_i) begin
            state_d        = DIV_IDLE;
            stallreq_o     = 1'b0;
            result_valid_o = 1'b0;
        end
        // Held low while in reset even if EX is presenting a divide
        if (!rst_ni) begin
            stallreq_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rem_op_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_o  <= '0;
        end else begin
            if (accept) begin
                cnt_q     <= '0;
                rem_op_q  <= in_rem;
                quo_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                quo_q     <= a_abs;
                rem_q     <= '0;
                dvs_q     <= b_abs;
                if (special) begin
                    result_o <= special_res;
                end
            end else if ((state_q == DIV_BUSY) && !flush_i) begin
                cnt_q <= cnt_q + 6'd1;
                quo_q <= quo_next;
                rem_q <= rem_next;
                if (cnt_q == LAST) begin
                    result_o <= final_res;
                end
            end
        end
    end

endmodule
